// File: rtl/mem_port_sequencer.sv
// mem_port_sequencer: arbitrates the single shared memory port between the
// instruction-fetch requester and the data load/store requester. One access
// is in flight at a time, and each access is followed by one idle turnaround
// cycle. Data requests always win over fetch requests.
//
// Requester handshake: a requester raises its req (level) with its address,
// plus write data for stores, and holds it. The sequencer samples those
// inputs only on the grant edge out of IDLE. It then answers with a
// single-cycle done pulse, with err set if the memory never responded.
// A req still high when the sequencer is back in IDLE starts a new access.
// Memory handshake: readM/writeM stay high until inputReady (reads) or
// ackOutput (writes) is sampled high on a rising edge, or until the wait
// counter reaches TIMEOUT.
module mem_port_sequencer #(
    parameter int WORD_SIZE = 16,
    parameter int TIMEOUT   = 255,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 if_req,
    input  logic [WORD_SIZE-1:0] if_addr,
    output logic [WORD_SIZE-1:0] if_data,
    output logic                 if_done,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 d_done,
    output logic                 err,
    output logic                 readM,
    output logic                 writeM,
    output logic [WORD_SIZE-1:0] address,
    inout  wire  [WORD_SIZE-1:0] data,
    input  logic                 inputReady,
    input  logic                 ackOutput
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DREAD   = 3'd2,
        DWRITE  = 3'd3,
        RECOVER = 3'd4
    } state_e;

    state_e               state_q,   state_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic [WORD_SIZE-1:0] address_q, address_d;
    logic [WORD_SIZE-1:0] wdata_q,   wdata_d;
    logic [WORD_SIZE-1:0] if_data_q, if_data_d;
    logic [WORD_SIZE-1:0] d_rdata_q, d_rdata_d;
    logic                 if_done_q, if_done_d;
    logic                 d_done_q,  d_done_d;
    logic                 err_q,     err_d;
    logic                 readM_q,   readM_d;
    logic                 writeM_q,  writeM_d;

    logic [CNT_W-1:0]     cnt_inc;
    logic                 timeout_hit;

    // The counter value this edge would store if the memory stays silent;
    // the access aborts when that value reaches TIMEOUT.
    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign timeout_hit = (cnt_inc == CNT_W'(TIMEOUT));

    // Next-state, capture and registered-output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        address_d = address_q;
        wdata_d   = wdata_q;
        if_data_d = if_data_q;
        d_rdata_d = d_rdata_q;
        if_done_d = 1'b0;
        d_done_d  = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (d_req) begin
                    state_d   = d_we ? DWRITE : DREAD;
                    address_d = d_addr;
                    wdata_d   = d_wdata;
                    cnt_d     = '0;
                end else if (if_req) begin
                    state_d   = FETCH;
                    address_d = if_addr;
                    cnt_d     = '0;
                end
            end
            FETCH: begin
                if (inputReady) begin
                    if_data_d = data;
                    if_done_d = 1'b1;
                    state_d   = RECOVER;
                end else if (timeout_hit) begin
                    if_done_d = 1'b1;
                    err_d     = 1'b1;
                    state_d   = RECOVER;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            DREAD: begin
                if (inputReady) begin
                    d_rdata_d = data;
                    d_done_d  = 1'b1;
                    state_d   = RECOVER;
                end else if (timeout_hit) begin
                    d_done_d = 1'b1;
                    err_d    = 1'b1;
                    state_d  = RECOVER;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            DWRITE: begin
                if (ackOutput) begin
                    d_done_d = 1'b1;
                    state_d  = RECOVER;
                end else if (timeout_hit) begin
                    d_done_d = 1'b1;
                    err_d    = 1'b1;
                    state_d  = RECOVER;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RECOVER: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Strobes are registered from the upcoming state, so they rise on
        // the grant edge and fall on the completion edge.
        readM_d  = (state_d == FETCH) || (state_d == DREAD);
        writeM_d = (state_d == DWRITE);
    end

    // State and output registers; reset drops strobes and the bus at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            address_q <= '0;
            wdata_q   <= '0;
            if_data_q <= '0;
            d_rdata_q <= '0;
            if_done_q <= 1'b0;
            d_done_q  <= 1'b0;
            err_q     <= 1'b0;
            readM_q   <= 1'b0;
            writeM_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            address_q <= address_d;
            wdata_q   <= wdata_d;
            if_data_q <= if_data_d;
            d_rdata_q <= d_rdata_d;
            if_done_q <= if_done_d;
            d_done_q  <= d_done_d;
            err_q     <= err_d;
            readM_q   <= readM_d;
            writeM_q  <= writeM_d;
        end
    end

    assign if_data = if_data_q;
    assign d_rdata = d_rdata_q;
    assign if_done = if_done_q;
    assign d_done  = d_done_q;
    assign err     = err_q;
    assign readM   = readM_q;
    assign writeM  = writeM_q;
    assign address = address_q;

    // The bus is driven only while the write strobe is high.
    assign data = writeM_q ? wdata_q : {WORD_SIZE{1'bz}};

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Bench for mem_port_sequencer: directed scenarios with literal
// expectations, then randomized requesters and memory checked every cycle
// against a transaction-level model of the port.
module tb_mem_port_sequencer;

    localparam int W  = 16;
    localparam int TO = 4;
    localparam int K_FETCH = 0;
    localparam int K_LOAD  = 1;
    localparam int K_STORE = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic          if_req, d_req, d_we, inputReady, ackOutput;
    logic [W-1:0]  if_addr, d_addr, d_wdata, mem_val;
    logic [W-1:0]  if_data, d_rdata, address;
    logic          if_done, d_done, err, readM, writeM;
    wire  [W-1:0]  data;

    // Memory side of the bus: drives whenever the sequencer is not writing.
    assign data = writeM ? {W{1'bz}} : mem_val;

    mem_port_sequencer #(.WORD_SIZE(W), .TIMEOUT(TO), .CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done), .err(err),
        .readM(readM), .writeM(writeM), .address(address), .data(data),
        .inputReady(inputReady), .ackOutput(ackOutput)
    );

    int checks   = 0;
    int failures = 0;
    logic cmp_en = 1'b0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp_v, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    // One access record at a time: who owns the port, what it latched,
    // how long it has waited; after completion one bus-quiet cycle.
    logic       acc_active = 1'b0;
    logic       quiet      = 1'b0;
    int         acc_kind   = 0;
    int         acc_waits  = 0;
    logic [W-1:0] e_addr = '0, e_wdata = '0, e_if_data = '0, e_d_rdata = '0;
    logic       e_if_done = 1'b0, e_d_done = 1'b0, e_err = 1'b0;
    logic [1:0] exp_q[$];   // completion order: {is_data, err}

    function automatic void finish_access(input logic timed_out);
        if (acc_kind == K_FETCH) e_if_done = 1'b1;
        else                     e_d_done  = 1'b1;
        e_err = timed_out;
        exp_q.push_back({(acc_kind != K_FETCH), timed_out});
        acc_active = 1'b0;
        quiet      = 1'b1;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_active = 1'b0; quiet = 1'b0; acc_waits = 0;
            e_addr = '0; e_if_data = '0; e_d_rdata = '0;
            e_if_done = 1'b0; e_d_done = 1'b0; e_err = 1'b0;
            exp_q.delete();
        end else begin
            e_if_done = 1'b0; e_d_done = 1'b0; e_err = 1'b0;
            if (quiet) begin
                quiet = 1'b0;
            end else if (acc_active) begin
                if (acc_kind == K_STORE ? ackOutput : inputReady) begin
                    if (acc_kind == K_FETCH) e_if_data = mem_val;
                    if (acc_kind == K_LOAD)  e_d_rdata = mem_val;
                    finish_access(1'b0);
                end else begin
                    acc_waits++;
                    if (acc_waits == TO) finish_access(1'b1);
                end
            end else if (d_req) begin
                acc_active = 1'b1; acc_waits = 0;
                acc_kind = d_we ? K_STORE : K_LOAD;
                e_addr = d_addr; e_wdata = d_wdata;
            end else if (if_req) begin
                acc_active = 1'b1; acc_waits = 0;
                acc_kind = K_FETCH;
                e_addr = if_addr;
            end
        end
    end

    // ---------------- scoreboard / compare ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            logic e_rd, e_wr;
            e_rd = acc_active && (acc_kind != K_STORE);
            e_wr = acc_active && (acc_kind == K_STORE);
            chk("readM",   W'(readM),   W'(e_rd));
            chk("writeM",  W'(writeM),  W'(e_wr));
            chk("address", address,     e_addr);
            chk("if_data", if_data,     e_if_data);
            chk("d_rdata", d_rdata,     e_d_rdata);
            chk("if_done", W'(if_done), W'(e_if_done));
            chk("d_done",  W'(d_done),  W'(e_d_done));
            chk("err",     W'(err),     W'(e_err));
            chk("data",    data,        e_wr ? e_wdata : mem_val);
            chk("one_strobe", W'(readM & writeM), '0);
            if (if_done || d_done) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL done_order actual=unexpected_done expected=none t=%0t", $time);
                end else begin
                    chk("done_order", W'({d_done, err}), W'(exp_q.pop_front()));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset_n = 1'b1;
        if_req = 0; d_req = 0; d_we = 0; inputReady = 0; ackOutput = 0;
        if_addr = '0; d_addr = '0; d_wdata = '0; mem_val = 16'h0F0F;
        #2 reset_n = 1'b0;
        cmp_en = 1'b1;
        tick(); tick();
        chk("rst_readM", W'(readM), '0);
        chk("rst_writeM", W'(writeM), '0);
        chk("rst_address", address, '0);
        chk("rst_if_data", if_data, '0);
        chk("rst_d_rdata", d_rdata, '0);
        chk("rst_done", W'({if_done, d_done, err}), '0);
        reset_n = 1'b1;
        tick();

        // Fetch, zero-wait memory.
        if_addr = 16'h0010; if_req = 1; tick();
        chk("f_readM", W'(readM), 16'h1);
        chk("f_addr", address, 16'h0010);
        inputReady = 1; mem_val = 16'h6A41; tick();
        chk("f_if_data", if_data, 16'h6A41);
        chk("f_if_done", W'(if_done), 16'h1);
        chk("f_readM_drop", W'(readM), '0);
        if_req = 0; inputReady = 0; tick();
        chk("f_done_pulse", W'(if_done), '0);

        // Store with three wait cycles; requester inputs change mid-access.
        d_req = 1; d_we = 1; d_addr = 16'h0080; d_wdata = 16'hBEEF; tick();
        d_addr = 16'hFFFF; d_wdata = 16'h0000; d_we = 0;
        for (int k = 0; k < 4; k++) begin
            chk("s_writeM", W'(writeM), 16'h1);
            chk("s_data", data, 16'hBEEF);
            chk("s_addr", address, 16'h0080);
            if (k == 3) ackOutput = 1;
            tick();
        end
        chk("s_d_done", W'(d_done), 16'h1);
        chk("s_writeM_drop", W'(writeM), '0);
        d_req = 0; ackOutput = 0; mem_val = 16'h5A5A; #1;
        chk("s_bus_release", data, 16'h5A5A);
        tick();
        chk("s_done_pulse", W'(d_done), '0);

        // Simultaneous requests: data first, then fetch.
        d_req = 1; d_we = 0; d_addr = 16'h0040; if_req = 1; if_addr = 16'h0100; tick();
        chk("p_readM", W'(readM), 16'h1);
        chk("p_addr", address, 16'h0040);
        inputReady = 1; mem_val = 16'h1234; tick();
        chk("p_d_rdata", d_rdata, 16'h1234);
        chk("p_d_done", W'(d_done), 16'h1);
        chk("p_if_done", W'(if_done), '0);
        d_req = 0; inputReady = 0; tick();
        chk("p_recover", W'(readM), '0);
        tick();
        chk("p_f_readM", W'(readM), 16'h1);
        chk("p_f_addr", address, 16'h0100);
        inputReady = 1; mem_val = 16'hCAFE; tick();
        chk("p_if_data", if_data, 16'hCAFE);
        chk("p_if_done", W'(if_done), 16'h1);
        if_req = 0; inputReady = 0; tick(); tick();

        // Load timeout; a write ack during the read must be ignored.
        d_req = 1; d_we = 0; d_addr = 16'h0042; ackOutput = 1; tick();
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("t_no_done", W'(d_done), '0);
            chk("t_readM", W'(readM), 16'h1);
        end
        tick();
        chk("t_d_done", W'(d_done), 16'h1);
        chk("t_err", W'(err), 16'h1);
        chk("t_d_rdata", d_rdata, 16'h1234);
        chk("t_readM_drop", W'(readM), '0);
        d_req = 0; ackOutput = 0; tick();
        chk("t_err_pulse", W'(err), '0);

        // Back-to-back fetches, memory always ready.
        if_req = 1; if_addr = 16'h0200; inputReady = 1;
        for (int k = 0; k < 9; k++) begin
            tick();
            chk("b2b_readM", W'(readM), W'(k % 3 == 0));
        end
        if_req = 0; inputReady = 0; tick();

        // Reset in the middle of a store.
        d_req = 1; d_we = 1; d_addr = 16'h0300; d_wdata = 16'h7777; tick(); tick();
        chk("r_writeM_before", W'(writeM), 16'h1);
        reset_n = 1'b0; d_req = 0; mem_val = 16'hA5A5; #1;
        chk("r_writeM", W'(writeM), '0);
        chk("r_bus", data, 16'hA5A5);
        chk("r_no_done", W'(d_done), '0);
        tick();
        reset_n = 1'b1; tick();
        chk("r_idle", W'({readM, writeM, d_done}), '0);
        if_req = 1; if_addr = 16'h0404; tick();
        chk("r_regrant", W'(readM), 16'h1);
        inputReady = 1; tick();
        if_req = 0; inputReady = 0; tick(); tick();

        // Randomized traffic at three memory response rates.
        for (int seg = 0; seg < 3; seg++) begin
            int p;
            p = (seg == 0) ? 60 : (seg == 1) ? 25 : 8;
            for (int c = 0; c < 600; c++) begin
                if (if_req && if_done) if_req = 1'($urandom_range(0, 1));
                else if (!if_req)      if_req = ($urandom_range(0, 3) == 0);
                if (d_req && d_done)   d_req = 1'($urandom_range(0, 1));
                else if (!d_req)       d_req = ($urandom_range(0, 3) == 0);
                if_addr    = W'($urandom);
                d_addr     = W'($urandom);
                d_wdata    = W'($urandom);
                d_we       = 1'($urandom);
                mem_val    = W'($urandom);
                inputReady = ($urandom_range(0, 99) < p);
                ackOutput  = ($urandom_range(0, 99) < p);
                if ($urandom_range(0, 299) == 0) begin
                    reset_n = 1'b0;
                    #2 reset_n = 1'b1;
                end
                tick();
            end
        end

        if_req = 0; d_req = 0; inputReady = 0; ackOutput = 0;
        repeat (TO + 4) tick();
        chk("queue_drained", W'(exp_q.size()), '0);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_sequencer.md
# mem_port_sequencer

Sequences the CPU's single shared memory port between the instruction-fetch requester and the data load/store requester. Grants one access at a time, drives `readM`/`writeM`/`address` and the bidirectional `data` bus, waits on the memory's `inputReady`/`ackOutput` handshake, and returns read data with a one-cycle completion pulse. Sits between the CPU datapath/control and the external memory model; the datapath never touches the memory pins directly.

## Interface
- `WORD_SIZE`, 16, address/data width
- `TIMEOUT`, 255, max wait cycles in an access state before abort (1..2^CNT_W-1)
- `CNT_W`, 8, wait-counter width
- `clk`  in  1  single clock, all state on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `if_req`  in  1  fetch request, level, held until `if_done`
- `if_addr`  in  WORD_SIZE  fetch address
- `if_data`  out  WORD_SIZE  fetched instruction, registered
- `if_done`  out  1  one-cycle completion pulse for fetch
- `d_req`  in  1  data request, level, held until `d_done`
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  WORD_SIZE  data address
- `d_wdata`  in  WORD_SIZE  store data
- `d_rdata`  out  WORD_SIZE  load data, registered
- `d_done`  out  1  one-cycle completion pulse for data access
- `err`  out  1  high with a done pulse when that access timed out
- `readM`  out  1  memory read strobe
- `writeM`  out  1  memory write strobe
- `address`  out  WORD_SIZE  memory address
- `data`  inout  WORD_SIZE  driven with store data only while `writeM`=1, else high-Z
- `inputReady`  in  1  memory: read data valid on `data`
- `ackOutput`  in  1  memory: write accepted

## Operation
- States: IDLE, FETCH, DREAD, DWRITE, RECOVER. Reset → IDLE.
- IDLE: `d_req`=1 → DREAD (`d_we`=0) or DWRITE (`d_we`=1); else `if_req`=1 → FETCH; else stay. Data has fixed priority over fetch.
- On grant: `address` registered from the granted requester's address; `d_wdata` captured into a write register; wait counter cleared. Requester inputs are not re-sampled until the next IDLE.
- FETCH/DREAD: `readM`=1. Sampling `inputReady`=1 at a rising edge → capture `data` into `if_data`/`d_rdata`, pulse done, → RECOVER.
- DWRITE: `writeM`=1, `data` driven with the captured store data. Sampling `ackOutput`=1 → pulse `d_done`, → RECOVER.
- `inputReady` is ignored outside FETCH/DREAD, `ackOutput` outside DWRITE.
- Wait counter increments every cycle in an access state without response; reaching `TIMEOUT` → strobes drop, done pulses with `err`=1, read result registers unchanged, → RECOVER.
- RECOVER: `readM`=`writeM`=0, bus high-Z for exactly one cycle, → IDLE. Guarantees strobe deassertion and bus turnaround between accesses.
- A request still high in IDLE after its done starts a new access.

## Timing
- Reset values: `readM`=`writeM`=0, `address`=0, `if_data`=`d_rdata`=0, `if_done`=`d_done`=`err`=0, `data` high-Z, counter 0. Asynchronous assertion; effective mid-access (strobes and bus drop immediately, no done pulse).
- All outputs are registered except `data`, whose tristate enable is `writeM`.
- Edge E0 in IDLE grants; strobe and `address` valid after E0. Response sampled first at E1. Minimum latency is grant to done pulse in 1 cycle (done high between E1 and E2). RECOVER occupies E1–E2, IDLE re-arbitrates at E3 ⇒ peak 3 cycles/access.
- Each extra memory wait cycle adds 1 cycle. Timeout: done/err asserted after the edge at which the counter equals `TIMEOUT`.
- Simultaneous `d_req` and `if_req`: data first, fetch granted in the next IDLE if still requested.
- `inputReady` and `ackOutput` high together in an access state: only the one matching the state is used.

## Test plan
- Reset mid-DWRITE (hold `ackOutput`=0, pulse `reset_n` low) → `writeM`=0 and `data` high-Z immediately, no `d_done`, IDLE after release.
- Fetch only, `if_addr`=0x0010, memory returns 0x6A41 with `inputReady` in the first cycle → `readM` high 1 cycle, `address`=0x0010, `if_data`=0x6A41, `if_done` 1-cycle pulse, IDLE 2 cycles after grant.
- Store, `d_addr`=0x0080, `d_wdata`=0xBEEF, `ackOutput` after 3 wait cycles → `data`=0xBEEF while `writeM`=1 for 4 cycles, one `d_done`, high-Z in RECOVER.
- `if_req` and `d_req` (load 0x0040→0x1234) raised same cycle → DREAD first, `d_rdata`=0x1234, then FETCH granted; never both strobes high.
- `TIMEOUT`=4, load with no `inputReady` → `d_done`=`err`=1 after 4 wait cycles, `d_rdata` unchanged, `readM` drops.
- Back-to-back fetches with `if_req` held, zero-wait memory → grants every 3 cycles, `readM` low ≥1 cycle between accesses.
